multistage_interconnect_network_output_buffer: RTL

Per-output-port elastic buffer directly downstream of `multistage_interconnect_network`. It captures the network's `valid`/`d_out` lanes, which are fire-and-forget with no stall, into one FIFO per output port. Each FIFO drains through its own valid/ready handshake. Per-port almost-full flags are returned upstream so injection logic can stop pushing before in-flight network traffic overruns a FIFO.

---
 rtl/multistage_interconnect_network_output_buffer_pkg.sv | 21 ++
 rtl/multistage_interconnect_network_port_fifo.sv | 73 +++++++
 rtl/multistage_interconnect_network_output_buffer.sv | 48 ++++
 3 files changed

// File: rtl/multistage_interconnect_network_output_buffer_pkg.sv
// multistage_interconnect_network_output_buffer_pkg: shared defaults and types for the output buffer
// Holds the default network geometry (ports, lane width) and the per-port FIFO sizing.
package multistage_interconnect_network_output_buffer_pkg;

    localparam int DEF_PORTS = 8;
    localparam int DEF_WIDTH = 128;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_SKID  = 4;

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } fifo_ctl_t;

    // Occupancy at which upstream injection must stop so in-flight words still fit.
    function automatic int afull_level(input int depth, input int skid);
        return depth - skid;
    endfunction

endpackage

// File: rtl/multistage_interconnect_network_port_fifo.sv
// multistage_interconnect_network_port_fifo: one first-word-fall-through FIFO for a single network output port
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, data_i  network word valid and data (no back-pressure possible)
//   pop_ready_i     consumer accepts the head word this cycle
//   valid_o, head_o FIFO non-empty and head word (zero while empty)
//   afull_o         occupancy at or above DEPTH-SKID
//   overflow_o      sticky: a word was dropped because the FIFO was full
module multistage_interconnect_network_port_fifo
    import multistage_interconnect_network_output_buffer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SKID  = DEF_SKID
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic             afull_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW + 1)'(afull_level(DEPTH, SKID));

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    fifo_ctl_t        ctl;

    // A full FIFO still accepts a push when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    always_comb begin
        ctl.pop  = (cnt_q != '0) && pop_ready_i;
        ctl.push = push_i && ((cnt_q != FULL_CNT) || ctl.pop);
        ctl.drop = push_i && !ctl.push;
        wr_d     = ctl.push ? wr_q + 1'b1 : wr_q;
        rd_d     = ctl.pop ? rd_q + 1'b1 : rd_q;
        cnt_d    = (ctl.push && !ctl.pop) ? cnt_q + 1'b1 :
                   (ctl.pop && !ctl.push) ? cnt_q - 1'b1 : cnt_q;
        ovf_d    = ovf_q || ctl.drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ctl.push) mem_q[wr_q] <= data_i;
    end

    assign valid_o    = cnt_q != '0;
    assign head_o     = valid_o ? mem_q[rd_q] : '0;
    assign afull_o    = cnt_q >= AFULL_CNT;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/multistage_interconnect_network_output_buffer.sv
// multistage_interconnect_network_output_buffer: per-output-port elastic buffers behind the interconnect network
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_i      network output valid, bit i is port i
//   d_in_i       network data, port i is d_in_i[i*WIDTH +: WIDTH]
//   afull_o      per-port almost-full, returned to injection logic
//   out_valid_o  per-port head valid
//   out_ready_i  per-port consumer ready
//   d_out_o      per-port head word, same lane slicing as d_in_i
//   overflow_o   per-port sticky drop flag
module multistage_interconnect_network_output_buffer
    import multistage_interconnect_network_output_buffer_pkg::*;
#(
    parameter int PORTS = DEF_PORTS,
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SKID  = DEF_SKID
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [0:PORTS-1]       valid_i,
    input  logic [PORTS*WIDTH-1:0] d_in_i,
    output logic [0:PORTS-1]       afull_o,
    output logic [0:PORTS-1]       out_valid_o,
    input  logic [0:PORTS-1]       out_ready_i,
    output logic [PORTS*WIDTH-1:0] d_out_o,
    output logic [0:PORTS-1]       overflow_o
);

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        multistage_interconnect_network_port_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH),
            .SKID (SKID)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push_i     (valid_i[i]),
            .data_i     (d_in_i[i*WIDTH +: WIDTH]),
            .pop_ready_i(out_ready_i[i]),
            .valid_o    (out_valid_o[i]),
            .head_o     (d_out_o[i*WIDTH +: WIDTH]),
            .afull_o    (afull_o[i]),
            .overflow_o (overflow_o[i])
        );
    end

endmodule
